mvp_shacc: RTL and testbench
============================

# mvp_shacc

Bit-serial shift-accumulator sitting directly downstream of the matrix-vector product stage (`mvp`). Each accepted beat carries one bit-plane of per-lane partial sums (the `S` bus of `mvp`). The block accumulates successive planes MSB-first as `acc = 2*acc ± plane`. After the last plane it presents one full-precision dot-product result per lane to the next stage through a valid/ready output register.

## Interface
- `n`, 256: number of lanes; power of 2, matches the `mvp` `n`.
- `iw`, `$clog2(n)+2`: per-lane input width, signed two's complement (matches the `mvp` lane width `a+2`).
- `aw`, 32: per-lane accumulator/output width; `aw > iw`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_first` input 1: beat is the first (MSB) plane of a new dot product.
- `in_last` input 1: beat is the final (LSB) plane.
- `in_neg` input 1: subtract this plane instead of adding it (two's-complement MSB plane).
- `in_s` input `n*iw`: lane i at `[i*iw +: iw]`, signed.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes the result.
- `out_acc` output `n*aw`: lane i at `[i*aw +: aw]`, signed.
- `out_planes` output 6: number of planes in the result, saturating at 63.
- `err` output 1: sticky protocol error flag.

## Operation
- The accept condition is `acc_en = in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. All beats stall while an unconsumed result is held.
- FSM states: IDLE (no product open) and ACC (product open).
- Per-lane term: `t = in_neg ? -sext(in_s) : sext(in_s)`, sign-extended from `iw` to `aw`.
- Accumulator update on `acc_en`:
  - Fresh start (IDLE, or `in_first` in any state): `acc = t`, `cnt = 1`.
  - Otherwise: `acc = (acc << 1) + t`, `cnt = sat63(cnt+1)`.
- All arithmetic wraps modulo 2^`aw`. No saturation and no overflow flag.
- Transitions:
  - IDLE→ACC on an accepted beat with `!in_last`.
  - ACC→IDLE on an accepted beat with `in_last`.
  - An accepted beat with `in_first && in_last` is a one-plane product and stays in or returns to IDLE.
- A beat accepted in IDLE without `in_first` is treated as a first plane. This is not an error.
- When `in_first` is accepted while in ACC, the open partial is discarded, `err` is set to 1, and accumulation restarts from `t`.
- Result capture: on an accepted beat with `in_last`:
  - `out_acc` is loaded with the updated lane values.
  - `out_planes` is loaded with the updated `cnt`.
  - `out_valid` is set to 1.
- `out_valid` clears on `out_valid && out_ready`, unless a new last beat is accepted in the same cycle, in which case it stays 1 with the new data.
- `out_acc` and `out_planes` hold their values while `out_valid && !out_ready`.
- Reset values:
  - Outputs: `out_valid=0`, `out_acc=0`, `out_planes=0`, `err=0`, `in_ready=1`.
  - Internal: FSM=IDLE, acc=0, cnt=0.
- Asserting `rst` mid-product discards the partial and any held result. The first beat after reset starts fresh.

## Timing
- One register stage. A last beat accepted at edge k gives `out_valid=1` with the result visible after edge k. No combinational path runs from `in_s` to `out_acc`.
- `in_ready` is combinational from `out_valid` and `out_ready` only.
- Throughput is one plane per cycle while `out_ready=1`, including back-to-back products (a last beat is followed by a first beat on the next cycle).
- A P-plane product occupies P input cycles. The result appears one cycle after the last beat.
- `err` sets on the edge that accepts the offending beat and clears only on `rst`.

## Test plan
Parameters for all cases: `n=4`, `iw=4`, `aw=16`, and `out_ready=1` unless stated.

1. **Two unsigned planes.** Lane0 gets s=3 (`first`), then s=1 (`last`); other lanes get 0.
   - Required: `out_acc` lane0=7, lanes1-3=0.
   - `out_planes=2`.
   - `out_valid` high exactly one cycle after the last beat.
2. **Signed MSB plane.** Lane1 gets s=2 with `in_neg=1,first`, then s=1 with `last`.
   - Required: lane1 = 0xFFFD (-3), `err=0`.
3. **Single plane.** Lane2 gets s=4'b1110 with `first&last`.
   - Required: lane2 = 0xFFFE, `out_planes=1`, FSM stays IDLE.
4. **Backpressure.** Hold `out_ready=0` after a result.
   - Required: `in_ready=0`, and a presented beat is not accepted; `out_acc` is stable.
   - Pulse `out_ready=1` for one cycle. Required: `in_ready=1` in that same cycle, the held beat is accepted, and `out_valid` drops unless that beat was a last.
5. **Restart.** Beats s=1 (`first`), s=1, s=5 (`first`), s=0 (`last`) on lane0.
   - Required: `err=1`, lane0=10, `out_planes=2`.
6. **Reset mid-product.** Assert `rst` for 1 cycle after two planes of a product.
   - Required: all outputs at their reset values.
   - A following product s=2 (`first`), s=1 (`last`) gives 5 with `err=0`.

Source files
------------

// File: rtl/mvp_shacc.sv
// Bit-serial shift-accumulator behind mvp: folds MSB-first bit-planes
// into per-lane results (acc = 2*acc +/- plane) and holds them for the consumer.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   in_valid/in_ready      input beat handshake
//   in_first/in_last       first (MSB) / final (LSB) plane markers
//   in_neg                 subtract this plane
//   in_s[n*iw]             per-lane signed partial sums
//   out_valid/out_ready    result handshake
//   out_acc[n*aw]          per-lane signed results
//   out_planes[6]          plane count of the result, saturating at 63
//   err                    sticky protocol error (first plane inside open product)
module mvp_shacc #(
  parameter int n  = 256,
  parameter int iw = $clog2(n) + 2,
  parameter int aw = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_neg,
  input  logic [n*iw-1:0] in_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [n*aw-1:0] out_acc,
  output logic [5:0]      out_planes,
  output logic            err
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [n*aw-1:0] acc_q, acc_d, acc_upd;
  logic [5:0]      cnt_q, cnt_d, cnt_upd;
  logic            ov_q, ov_d;
  logic [n*aw-1:0] oacc_q, oacc_d;
  logic [5:0]      opl_q, opl_d;
  logic            err_q, err_d;

  logic acc_en;
  logic fresh;
  logic cap;

  assign in_ready = !ov_q || out_ready;
  assign acc_en   = in_valid && in_ready;
  // An unopened product always restarts, marker or not.
  assign fresh    = (state_q == IDLE) || in_first;
  assign cap      = acc_en && in_last;

  for (genvar i = 0; i < n; i++) begin : g_lane
    logic [iw-1:0] s;
    logic [aw-1:0] sx, t, prev;
    assign s    = in_s[i*iw +: iw];
    assign sx   = {{(aw-iw){s[iw-1]}}, s};
    assign t    = in_neg ? (~sx + 1'b1) : sx;
    assign prev = acc_q[i*aw +: aw];
    assign acc_upd[i*aw +: aw] = fresh ? t : ((prev << 1) + t);
  end

  assign cnt_upd = fresh ? 6'd1 :
                   (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ov_d    = ov_q;
    oacc_d  = oacc_q;
    opl_d   = opl_q;
    if (acc_en) begin
      acc_d   = acc_upd;
      cnt_d   = cnt_upd;
      state_d = in_last ? IDLE : ACC;
      if (in_first && (state_q == ACC))
        err_d = 1'b1;
    end
    // A new capture wins over the consumer draining the old result.
    if (cap) begin
      ov_d   = 1'b1;
      oacc_d = acc_upd;
      opl_d  = cnt_upd;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      ov_q   <= 1'b0;
      oacc_q <= '0;
      opl_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      ov_q   <= ov_d;
      oacc_q <= oacc_d;
      opl_q  <= opl_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_acc    = oacc_q;
  assign out_planes = opl_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mvp_shacc.sv
// Self-checking bench for mvp_shacc (n=4, iw=4, aw=16).
// Reference keeps the planes of each product and sums t*2^k at the end.
module tb_mvp_shacc;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic          in_neg = 1'b0;
  logic [N*IW-1:0] in_s = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N*AW-1:0] out_acc;
  logic [5:0]    out_planes;
  logic          err;

  int checks = 0;
  int failures = 0;

  // reference state
  int          pl[N][$];
  bit          m_open;
  bit          m_ov;
  bit          m_err;
  logic [15:0] m_acc[N];
  int          m_pl;

  mvp_shacc #(.n(N), .iw(IW), .aw(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .in_neg(in_neg), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_planes(out_planes),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      pl[i].delete();
      m_acc[i] = '0;
    end
    m_open = 0;
    m_ov = 0;
    m_err = 0;
    m_pl = 0;
  endtask

  // One clock edge worth of specified behaviour, on the sampled inputs.
  task automatic m_step();
    bit acc;
    acc = in_valid && (!m_ov || out_ready);
    if (acc) begin
      if (in_first && m_open) m_err = 1;
      for (int i = 0; i < N; i++) begin
        logic signed [3:0] x;
        int t;
        x = in_s[i*IW +: IW];
        t = x;
        if (in_neg) t = -t;
        if (!m_open || in_first) pl[i].delete();
        pl[i].push_back(t);
      end
      if (in_last) begin
        for (int i = 0; i < N; i++) begin
          longint r;
          int p;
          r = 0;
          p = pl[i].size();
          for (int k = 0; k < p; k++) begin
            int sh;
            sh = p - 1 - k;
            if (sh < AW) r += longint'(pl[i][k]) <<< sh;
          end
          m_acc[i] = r[15:0];
        end
        m_pl = (pl[0].size() > 63) ? 63 : pl[0].size();
        m_ov = 1;
        m_open = 0;
      end else begin
        m_open = 1;
        if (m_ov && out_ready) m_ov = 0;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, m_ov);
    chk("err", err, m_err);
    chk("out_planes", out_planes, m_pl);
    for (int i = 0; i < N; i++)
      chk($sformatf("out_acc%0d", i), out_acc[i*AW +: AW], m_acc[i]);
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input logic ng, input logic [15:0] s,
                       input logic ordy);
    in_valid = v;
    in_first = f;
    in_last = l;
    in_neg = ng;
    in_s = s;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !m_ov || ordy);
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    compare();
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [15:0] hold;
    m_reset();
    @(negedge clk);
    compare();
    do_reset();

    // 1: two unsigned planes
    drive(1, 1, 0, 0, 16'h0003, 1);
    chk("t1_nv", out_valid, 0);
    drive(1, 0, 1, 0, 16'h0001, 1);
    chk("t1_lane0", out_acc[15:0], 7);
    chk("t1_lane1", out_acc[31:16], 0);
    chk("t1_planes", out_planes, 2);
    drive(0, 0, 0, 0, 16'h0000, 1);
    chk("t1_drop", out_valid, 0);

    // 2: signed MSB plane
    drive(1, 1, 0, 1, 16'h0020, 1);
    drive(1, 0, 1, 0, 16'h0010, 1);
    chk("t2_lane1", out_acc[31:16], 16'hFFFD);
    chk("t2_err", err, 0);

    // 3: single plane, stays idle (next beat w/o first opens cleanly)
    drive(1, 1, 1, 0, 16'h0E00, 1);
    chk("t3_lane2", out_acc[47:32], 16'hFFFE);
    chk("t3_planes", out_planes, 1);
    drive(1, 0, 1, 0, 16'h0001, 1);
    chk("t3_idle", err, 0);
    chk("t3b_lane0", out_acc[15:0], 1);

    // 4: backpressure
    drive(1, 1, 1, 0, 16'h0005, 0);
    hold = out_acc[15:0];
    drive(1, 1, 0, 0, 16'h0002, 0);
    chk("t4_rdy", in_ready, 0);
    drive(1, 1, 0, 0, 16'h0002, 0);
    chk("t4_hold", out_acc[15:0], hold);
    drive(1, 1, 0, 0, 16'h0002, 1);
    chk("t4_drop", out_valid, 0);
    drive(1, 0, 1, 0, 16'h0001, 1);
    chk("t4_lane0", out_acc[15:0], 5);

    // 5: restart inside open product
    drive(1, 1, 0, 0, 16'h0001, 1);
    drive(1, 0, 0, 0, 16'h0001, 1);
    drive(1, 1, 0, 0, 16'h0005, 1);
    drive(1, 0, 1, 0, 16'h0000, 1);
    chk("t5_err", err, 1);
    chk("t5_lane0", out_acc[15:0], 10);
    chk("t5_planes", out_planes, 2);

    // 6: reset mid-product
    drive(1, 1, 0, 0, 16'h0003, 1);
    drive(1, 0, 0, 0, 16'h0003, 1);
    do_reset();
    chk("t6_acc", out_acc, 0);
    drive(1, 1, 0, 0, 16'h0002, 1);
    drive(1, 0, 1, 0, 16'h0001, 1);
    chk("t6_lane0", out_acc[15:0], 5);
    chk("t6_err", err, 0);

    // plane counter saturation
    drive(1, 1, 0, 0, 16'h0001, 1);
    for (int k = 0; k < 68; k++)
      drive(1, 0, 0, 0, 16'h0000, 1);
    drive(1, 0, 1, 0, 16'h0001, 1);
    chk("sat_planes", out_planes, 63);
    chk("sat_lane0", out_acc[15:0], 1);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 1) == 1,
              16'($urandom),
              $urandom_range(0, 9) < 7);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
